// File: rtl/aibcr3_dcc_cal_ctrl.sv
// DCC calibration sequencer: bang-bang search of the combined coarse/interpolator
// delay code, lock on repeated dither reversals, with bypass and manual override.
module aibcr3_dcc_cal_ctrl #(
    parameter int unsigned CRS_W      = 4,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned LOCK_CNT   = 4,
    localparam int unsigned CW        = CRS_W + 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rb_dcc_byp,
    input  logic             rb_dcc_en,
    input  logic             rb_dcc_manual,
    input  logic [CW-1:0]    rb_dcc_manual_code,
    input  logic             dcc_cmp,
    output logic [CRS_W-1:0] dly_coarse,
    output logic [6:0]       interp_therm,
    output logic             dcc_byp_sel,
    output logic             dcc_busy,
    output logic             dcc_lock,
    output logic             dcc_sat,
    output logic [CW-1:0]    dcc_code
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_SETTLE,
        ST_SAMPLE,
        ST_LOCKED,
        ST_MANUAL
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DN
    } dir_t;

    localparam logic [CW-1:0] CODE_MID    = {1'b1, {(CW-1){1'b0}}};
    localparam logic [CW-1:0] CODE_MAX    = '1;
    localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [3:0]    LOCK_TGT    = 4'(LOCK_CNT);

    state_t             state_q, state_d;
    logic [CW-1:0]      code_q, code_d;
    logic [7:0]         settle_cnt_q, settle_cnt_d;
    logic [3:0]         rev_cnt_q, rev_cnt_d;
    dir_t               last_dir_q, last_dir_d;
    logic               sat_q, sat_d;
    logic               lock_q, lock_d;
    logic               busy_q, busy_d;
    logic               byp_sel_q, byp_sel_d;
    logic [CRS_W-1:0]   coarse_q, coarse_d;
    logic [6:0]         therm_q, therm_d;

    dir_t               step_dir;
    logic [3:0]         rev_next;

    // Next-state, code search and decoded datapath controls
    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        settle_cnt_d = settle_cnt_q;
        rev_cnt_d    = rev_cnt_q;
        last_dir_d   = last_dir_q;
        sat_d        = sat_q;
        byp_sel_d    = rb_dcc_byp;
        step_dir     = DIR_NONE;
        rev_next     = '0;

        if (rb_dcc_byp) begin
            state_d = ST_IDLE;
            code_d  = CODE_MID;
            sat_d   = 1'b0;
        end else if (rb_dcc_manual) begin
            state_d = ST_MANUAL;
            code_d  = rb_dcc_manual_code;
        end else if (!rb_dcc_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_INIT;
                ST_INIT: begin
                    code_d       = CODE_MID;
                    settle_cnt_d = '0;
                    rev_cnt_d    = '0;
                    last_dir_d   = DIR_NONE;
                    sat_d        = 1'b0;
                    state_d      = ST_SETTLE;
                end
                ST_SETTLE: begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_d = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    step_dir = dcc_cmp ? DIR_UP : DIR_DN;
                    // A blocked step still counts as a step in its direction.
                    if (dcc_cmp) begin
                        if (code_q == CODE_MAX) sat_d = 1'b1;
                        else                    code_d = code_q + 1'b1;
                    end else begin
                        if (code_q == '0) sat_d = 1'b1;
                        else              code_d = code_q - 1'b1;
                    end
                    if ((last_dir_q != DIR_NONE) && (step_dir != last_dir_q)) begin
                        rev_next = rev_cnt_q + 4'd1;
                    end
                    rev_cnt_d  = rev_next;
                    last_dir_d = step_dir;
                    if (rev_next == LOCK_TGT) begin
                        state_d = ST_LOCKED;
                    end else begin
                        settle_cnt_d = '0;
                        state_d      = ST_SETTLE;
                    end
                end
                ST_LOCKED: state_d = ST_LOCKED;
                ST_MANUAL: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end

        lock_d   = (state_d == ST_LOCKED);
        busy_d   = (state_d inside {ST_INIT, ST_SETTLE, ST_SAMPLE});
        coarse_d = code_d[CW-1:3];
        therm_d  = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            therm_d[i] = (i < 32'(code_d[2:0]));
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            code_q       <= CODE_MID;
            settle_cnt_q <= '0;
            rev_cnt_q    <= '0;
            last_dir_q   <= DIR_NONE;
            sat_q        <= 1'b0;
            lock_q       <= 1'b0;
            busy_q       <= 1'b0;
            byp_sel_q    <= 1'b0;
            coarse_q     <= CODE_MID[CW-1:3];
            therm_q      <= '0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            settle_cnt_q <= settle_cnt_d;
            rev_cnt_q    <= rev_cnt_d;
            last_dir_q   <= last_dir_d;
            sat_q        <= sat_d;
            lock_q       <= lock_d;
            busy_q       <= busy_d;
            byp_sel_q    <= byp_sel_d;
            coarse_q     <= coarse_d;
            therm_q      <= therm_d;
        end
    end

    assign dly_coarse   = coarse_q;
    assign interp_therm = therm_q;
    assign dcc_byp_sel  = byp_sel_q;
    assign dcc_busy     = busy_q;
    assign dcc_lock     = lock_q;
    assign dcc_sat      = sat_q;
    assign dcc_code     = code_q;

endmodule

// File: tb/tb_aibcr3_dcc_cal_ctrl.sv
// Bench for aibcr3_dcc_cal_ctrl: integer-level reference model plus literal anchors.
module tb_aibcr3_dcc_cal_ctrl;

    localparam int CRS_W      = 4;
    localparam int SETTLE_CYC = 8;
    localparam int LOCK_CNT   = 4;
    localparam int CW         = CRS_W + 3;
    localparam int MID        = 1 << (CW - 1);
    localparam int MAXC       = (1 << CW) - 1;

    localparam int P_IDLE = 0;
    localparam int P_INIT = 1;
    localparam int P_CAL  = 2;
    localparam int P_LOCK = 3;
    localparam int P_MAN  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            byp = 1'b0;
    logic            en  = 1'b0;
    logic            man = 1'b0;
    logic            cmp = 1'b0;
    logic [CW-1:0]   mcode = '0;

    logic [CRS_W-1:0] dly_coarse;
    logic [6:0]       interp_therm;
    logic             dcc_byp_sel;
    logic             dcc_busy;
    logic             dcc_lock;
    logic             dcc_sat;
    logic [CW-1:0]    dcc_code;

    int vectors    = 0;
    int miscompares = 0;

    // model state
    int m_ph, m_code, m_k, m_rev, m_ld;
    bit m_sat, m_bsel;

    always #5 clk = ~clk;

    aibcr3_dcc_cal_ctrl #(
        .CRS_W      (CRS_W),
        .SETTLE_CYC (SETTLE_CYC),
        .LOCK_CNT   (LOCK_CNT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .rb_dcc_byp         (byp),
        .rb_dcc_en          (en),
        .rb_dcc_manual      (man),
        .rb_dcc_manual_code (mcode),
        .dcc_cmp            (cmp),
        .dly_coarse         (dly_coarse),
        .interp_therm       (interp_therm),
        .dcc_byp_sel        (dcc_byp_sel),
        .dcc_busy           (dcc_busy),
        .dcc_lock           (dcc_lock),
        .dcc_sat            (dcc_sat),
        .dcc_code           (dcc_code)
    );

    task automatic model_step();
        int d;
        if (rst) begin
            m_ph = P_IDLE; m_code = MID; m_sat = 0; m_bsel = 0;
            m_k = 0; m_rev = 0; m_ld = 0;
        end else begin
            m_bsel = byp;
            if (byp) begin
                m_ph = P_IDLE; m_code = MID; m_sat = 0;
            end else if (man) begin
                m_ph = P_MAN; m_code = int'(mcode);
            end else if (!en) begin
                m_ph = P_IDLE;
            end else begin
                case (m_ph)
                    P_IDLE: m_ph = P_INIT;
                    P_INIT: begin
                        m_code = MID; m_sat = 0; m_rev = 0; m_ld = 0; m_k = 0;
                        m_ph = P_CAL;
                    end
                    P_CAL: begin
                        if (m_k < SETTLE_CYC) begin
                            m_k++;
                        end else begin
                            d = cmp ? 1 : -1;
                            if (m_code + d < 0 || m_code + d > MAXC) m_sat = 1;
                            else m_code = m_code + d;
                            m_rev = (m_ld != 0 && d != m_ld) ? m_rev + 1 : 0;
                            m_ld = d;
                            if (m_rev == LOCK_CNT) m_ph = P_LOCK;
                            else m_k = 0;
                        end
                    end
                    P_MAN: m_ph = P_IDLE;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check_cycle();
        logic [21:0] exp_v, act_v;
        logic busy_e, lock_e;
        busy_e = (m_ph == P_INIT) || (m_ph == P_CAL);
        lock_e = (m_ph == P_LOCK);
        exp_v = {7'(m_code), 4'(m_code / 8), 7'((1 << (m_code % 8)) - 1),
                 m_bsel, busy_e, lock_e, m_sat};
        act_v = {dcc_code, dly_coarse, interp_therm, dcc_byp_sel, dcc_busy, dcc_lock, dcc_sat};
        vectors++;
        if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL model_cycle t=%0t got code=%h crs=%h th=%b bs=%b bz=%b lk=%b st=%b want code=%h crs=%h th=%b bs=%b bz=%b lk=%b st=%b",
                     $time, act_v[21:15], act_v[14:11], act_v[10:4], act_v[3], act_v[2], act_v[1], act_v[0],
                     exp_v[21:15], exp_v[14:11], exp_v[10:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic wait_init(input int budget);
        int n = 0;
        while (m_ph != P_INIT && n < budget) begin
            tick();
            cmp = (m_code < 70);
            n++;
        end
        chk("reach_init", m_ph, P_INIT);
    endtask

    initial begin
        int n;
        int tgt;

        // reset with random inputs
        byp = 1'($urandom); en = 1'($urandom); man = 1'($urandom);
        cmp = 1'($urandom); mcode = CW'($urandom);
        repeat (3) begin
            tick();
            byp = 1'($urandom); en = 1'($urandom); man = 1'($urandom);
            cmp = 1'($urandom); mcode = CW'($urandom);
        end
        chk("rst_coarse", int'(dly_coarse), 8);
        chk("rst_therm", int'(interp_therm), 0);
        chk("rst_lock", int'(dcc_lock), 0);
        chk("rst_busy", int'(dcc_busy), 0);
        chk("rst_byp_sel", int'(dcc_byp_sel), 0);
        chk("rst_code", int'(dcc_code), 64);
        rst = 0; byp = 0; man = 0; en = 0; cmp = 0;
        tick();

        // convergence toward 70
        en = 1;
        wait_init(5);
        n = 0;
        while (m_ph != P_LOCK && n < 300) begin
            tick();
            n++;
            cmp = (m_code < 70);
        end
        chk("lock_latency", n, 91);
        chk("lock_flag", int'(dcc_lock), 1);
        chk("lock_code", int'(dcc_code), 70);
        chk("lock_coarse", int'(dly_coarse), 8);
        chk("lock_therm", int'(interp_therm), 7'b0111111);
        chk("lock_sat", int'(dcc_sat), 0);
        chk("lock_busy", int'(dcc_busy), 0);
        repeat (20) begin
            tick();
            cmp = 1'($urandom);
        end
        chk("frozen_code", int'(dcc_code), 70);
        chk("frozen_lock", int'(dcc_lock), 1);

        // bypass wins over manual and enable while locked
        byp = 1; man = 1; en = 1; mcode = CW'($urandom);
        tick();
        chk("byp_sel", int'(dcc_byp_sel), 1);
        chk("byp_lock", int'(dcc_lock), 0);
        chk("byp_code", int'(dcc_code), 64);
        chk("byp_busy", int'(dcc_busy), 0);
        byp = 0; man = 0; en = 0;
        tick();
        chk("byp_sel_drop", int'(dcc_byp_sel), 0);

        // saturation at all-ones
        en = 1; cmp = 1;
        while (m_ph != P_INIT && n < 1000) begin tick(); n++; end
        cmp = 1;
        chk("sat_init", m_ph, P_INIT);
        repeat (1 + 63 * 9) tick();
        chk("sat_reach_code", int'(dcc_code), 127);
        chk("sat_reach_flag", int'(dcc_sat), 0);
        repeat (9) tick();
        chk("sat_hold_code", int'(dcc_code), 127);
        chk("sat_flag", int'(dcc_sat), 1);
        repeat (30) tick();
        chk("sat_nolock", int'(dcc_lock), 0);
        chk("sat_busy", int'(dcc_busy), 1);
        chk("sat_code_end", int'(dcc_code), 127);

        // manual override mid-calibration
        man = 1; mcode = 7'h2B;
        tick();
        chk("man_code", int'(dcc_code), 'h2B);
        chk("man_coarse", int'(dly_coarse), 5);
        chk("man_therm", int'(interp_therm), 7'b0000111);
        chk("man_busy", int'(dcc_busy), 0);
        repeat (4) begin
            mcode = CW'($urandom);
            tick();
        end
        man = 0;
        tick();
        chk("man_exit_idle_busy", int'(dcc_busy), 0);
        tick();
        chk("man_exit_init_busy", int'(dcc_busy), 1);
        tick();
        chk("man_reinit_code", int'(dcc_code), 64);
        chk("man_reinit_sat", int'(dcc_sat), 0);

        // reset during the third settle window
        repeat (2 * 9 + 3) begin
            cmp = 1'($urandom);
            tick();
        end
        rst = 1;
        tick();
        chk("mid_rst_code", int'(dcc_code), 64);
        chk("mid_rst_coarse", int'(dly_coarse), 8);
        chk("mid_rst_therm", int'(interp_therm), 0);
        chk("mid_rst_busy", int'(dcc_busy), 0);
        chk("mid_rst_lock", int'(dcc_lock), 0);
        chk("mid_rst_sat", int'(dcc_sat), 0);
        rst = 0;
        tick();
        chk("mid_rst_init_busy", int'(dcc_busy), 1);
        tick();
        chk("mid_rst_restart_code", int'(dcc_code), 64);

        // randomized soak
        tgt = int'($urandom_range(MAXC, 0));
        repeat (4000) begin
            rst = ($urandom_range(399, 0) == 0);
            if ($urandom_range(59, 0) == 0) en = ~en;
            if ($urandom_range(149, 0) == 0) man = ~man;
            if ($urandom_range(199, 0) == 0) byp = ~byp;
            if ($urandom_range(299, 0) == 0) tgt = int'($urandom_range(MAXC + 8, 0));
            mcode = CW'($urandom);
            cmp = ($urandom_range(3, 0) == 0) ? 1'($urandom) : (m_code < tgt);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aibcr3_dcc_cal_ctrl.md
Name: aibcr3_dcc_cal_ctrl

Overview:
- Calibration sequencer for the DCC delay path (coarse delay cell plus 7-leg thermometer interpolator).
- Steps a combined delay code with bang-bang updates from a synchronized duty/phase compare input.
- Declares lock after repeated dither reversals, then freezes the code.
- Handles register-bit bypass and manual-code override, and drives the delay-cell code, interpolator legs and bypass select of the DCC datapath.

Parameters:
- CRS_W, 4, coarse delay-cell code width; total code width CW = CRS_W+3.
- SETTLE_CYC, 8, cycles waited after each code change before sampling the compare input (valid range 1..255).
- LOCK_CNT, 4, consecutive direction reversals required to declare lock (valid range 1..15).

Ports:
- clk  input  1  calibration clock.
- rst  input  1  synchronous, active-high reset.
- rb_dcc_byp  input  1  register bit: bypass DCC.
- rb_dcc_en  input  1  register bit: level-enable calibration.
- rb_dcc_manual  input  1  register bit: use manual code.
- rb_dcc_manual_code  input  CW  manual code value.
- dcc_cmp  input  1  synchronized compare result; 1 = increase delay.
- dly_coarse  output  CRS_W  coarse delay-cell code = code[CW-1:3].
- interp_therm  output  7  interpolator legs; thermometer of code[2:0] (n gives the low n bits set).
- dcc_byp_sel  output  1  registered copy of rb_dcc_byp, drives the datapath clock mux.
- dcc_busy  output  1  1 while in INIT, SETTLE or SAMPLE.
- dcc_lock  output  1  calibration locked.
- dcc_sat  output  1  code hit 0 or all-ones during calibration.
- dcc_code  output  CW  current code (status readback).

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, code=MID=2^(CW-1) (64 at defaults, giving dly_coarse=8, interp_therm=0), dcc_byp_sel=0, dcc_busy=0, dcc_lock=0, dcc_sat=0. Internal counters cleared; last_dir=none.
- States: IDLE, INIT, SETTLE, SAMPLE, LOCKED, MANUAL.
- Priority, evaluated every cycle from any state: rb_dcc_byp > rb_dcc_manual > rb_dcc_en.
  - rb_dcc_byp=1: next state IDLE, code=MID, dcc_lock=0, dcc_sat=0. dcc_byp_sel follows rb_dcc_byp with 1-cycle latency in all states.
  - Else rb_dcc_manual=1: next state MANUAL; code=rb_dcc_manual_code, registered with 1-cycle latency and updated every cycle while in MANUAL; dcc_lock=0, dcc_busy=0.
  - Else rb_dcc_en=0: next state IDLE; code holds its last value; dcc_lock=0.
- IDLE with rb_dcc_en=1: go to INIT.
- INIT (1 cycle): code=MID, settle_cnt=0, rev_cnt=0, last_dir=none, dcc_sat=0; go to SETTLE.
- SETTLE: settle_cnt increments each cycle; after SETTLE_CYC cycles in SETTLE, go to SAMPLE.
- SAMPLE (1 cycle): dir = dcc_cmp ? up : down.
  - up: code+1, saturating at all-ones. down: code-1, saturating at 0.
  - If the step would overflow, code holds and dcc_sat=1; the step still counts as a step in dir.
  - If last_dir ≠ none and dir ≠ last_dir: rev_cnt+1. Otherwise rev_cnt=0.
  - last_dir=dir.
  - If rev_cnt reaches LOCK_CNT on this update: the code update still applies, then go to LOCKED. Otherwise settle_cnt=0 and go to SETTLE.
  - One update every SETTLE_CYC+1 cycles.
- LOCKED: code frozen, dcc_lock=1, dcc_busy=0. Stays in LOCKED until en/manual/byp changes per the priority rules. Recalibration requires rb_dcc_en to drop and rise again.
- dcc_sat is sticky until INIT, bypass or reset.
- dcc_cmp is ignored outside SAMPLE.
- Reset mid-calibration overrides everything; all values return to the reset values above on the next edge.
- Leaving MANUAL with en=1 and manual=0 goes through IDLE then INIT, i.e. a fresh calibration from MID.

Test Plan:
- Reset: assert rst for 3 cycles with all inputs random -> dly_coarse=8, interp_therm=7'b0000000, dcc_lock=0, dcc_busy=0, dcc_byp_sel=0, dcc_code=64.
- Convergence: rb_dcc_en=1, model dcc_cmp=(code<70) -> code sequence 64,65,...,70,69,70,69,70; dcc_lock=1 at code 70 (dly_coarse=8, interp_therm=7'b0111111) exactly 1+10*9=91 cycles after INIT entry; dcc_sat=0; code then frozen regardless of dcc_cmp.
- Saturation: dcc_cmp stuck at 1 -> code reaches 127 after 63 updates, holds at 127, dcc_sat=1, dcc_lock never asserts, dcc_busy stays 1.
- Manual override mid-calibration: set rb_dcc_manual=1 with code 7'h2B -> next cycle dcc_code=0x2B, dly_coarse=5, interp_therm=7'b0000111, dcc_busy=0; clear manual -> INIT reloads 64.
- Bypass priority: rb_dcc_byp=1 together with manual=1 and en=1 while LOCKED -> next cycle dcc_byp_sel=1, dcc_lock=0, code=64, state IDLE.
- Reset mid-SETTLE: pulse rst for 1 cycle during step 3 -> all outputs at reset values on the next edge; with en still 1, INIT follows and calibration restarts from 64.
